// File: rtl/inst_axi_bridge_pkg.sv
// Shared AXI encodings and local types for the instruction-side read bridge.
package inst_axi_bridge_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

   // Counter width covers MAX_OUTST up to 7.
   localparam int CNT_W = 3;

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_SEND = 1'b1
   } ar_state_e;

endpackage

// File: rtl/inst_axi_bridge_chk.sv
// Protocol and invariant checks for the instruction-side bridge.
module inst_axi_bridge_chk
   import inst_axi_bridge_pkg::*;
#(
   parameter int MAX_OUTST = 2
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_req,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_outst_cnt,
   input  logic [CNT_W-1:0] i_drop_cnt
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

   // IF must never issue a write on the instruction port.
   a_no_write: assert property (@(posedge clk) disable iff (!resetn) !(i_req && i_wr));

   // Outstanding count stays inside its configured bound.
   a_outst_max: assert property (@(posedge clk) disable iff (!resetn) i_outst_cnt <= MAX_C);

   // Only fetches that are actually outstanding can be marked for dropping.
   a_drop_le: assert property (@(posedge clk) disable iff (!resetn) i_drop_cnt <= i_outst_cnt);

endmodule

// File: rtl/inst_axi_bridge.sv
// Instruction-side bridge: SRAM-like fetch port to single-beat AXI reads,
// in-order return, with cancel support that discards in-flight responses.
module inst_axi_bridge
   import inst_axi_bridge_pkg::*;
#(
   parameter int         MAX_OUTST = 2,
   parameter logic [3:0] ARID_VAL  = 4'd0
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addrok,
   output logic        inst_sram_dataok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_wr_pending,
   input  logic        fetch_cancel,
   output logic        inst_bus_err,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_OUTST);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   ar_state_e        r_state;
   ar_state_e        w_state_nxt;
   logic             w_addrok;
   logic             w_rready;
   logic             w_r_done;
   logic             w_take;
   logic [CNT_W-1:0] r_outst_cnt;
   logic [CNT_W-1:0] r_drop_cnt;
   logic [CNT_W-1:0] w_outst_nxt;
   logic [CNT_W-1:0] w_drop_nxt;
   logic [31:0]      r_araddr;
   logic [2:0]       r_arsize;
   logic [31:0]      r_rdata;
   logic             r_dataok;
   logic             r_bus_err;
   logic             w_unused;

   // The write flag is treated as a read; wdata and rid carry no meaning here.
   assign w_unused = &{1'b0, inst_sram_wdata, rid};

   assign w_rready = (r_outst_cnt != CNT_ZERO);
   assign w_r_done = rvalid && w_rready && rlast;
   // A beat is delivered only when no pre-cancel fetch is ahead of it and no
   // cancel arrives in the same cycle.
   assign w_take   = w_r_done && (r_drop_cnt == CNT_ZERO) && !fetch_cancel;

   // AR FSM next state and the combinational address-accept strobe.
   always_comb begin
      w_state_nxt = r_state;
      w_addrok    = 1'b0;
      case (r_state)
         AR_IDLE: begin
            w_addrok = resetn && inst_sram_req && !data_wr_pending && (r_outst_cnt < MAX_C);
            if (w_addrok) w_state_nxt = AR_SEND;
            else          w_state_nxt = AR_IDLE;
         end
         AR_SEND: begin
            if (arready) w_state_nxt = AR_IDLE;
            else         w_state_nxt = AR_SEND;
         end
         default: begin
            w_state_nxt = AR_IDLE;
         end
      endcase
   end

   // Next values of the outstanding and drop counters.
   always_comb begin
      w_outst_nxt = r_outst_cnt;
      w_drop_nxt  = r_drop_cnt;
      if (w_addrok && !w_r_done)      w_outst_nxt = r_outst_cnt + CNT_ONE;
      else if (!w_addrok && w_r_done) w_outst_nxt = r_outst_cnt - CNT_ONE;
      else                            w_outst_nxt = r_outst_cnt;
      // A fetch accepted in the cancel cycle is post-cancel, so it is not counted.
      if (fetch_cancel) begin
         if (w_r_done) w_drop_nxt = r_outst_cnt - CNT_ONE;
         else          w_drop_nxt = r_outst_cnt;
      end else if (w_r_done && (r_drop_cnt != CNT_ZERO)) begin
         w_drop_nxt = r_drop_cnt - CNT_ONE;
      end else begin
         w_drop_nxt = r_drop_cnt;
      end
   end

   // State register and counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= AR_IDLE;
         r_outst_cnt <= CNT_ZERO;
         r_drop_cnt  <= CNT_ZERO;
      end else begin
         r_state     <= w_state_nxt;
         r_outst_cnt <= w_outst_nxt;
         r_drop_cnt  <= w_drop_nxt;
      end
   end

   // AR payload captured on accept and held stable until the handshake.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_araddr <= 32'h0000_0000;
         r_arsize <= 3'd0;
      end else if (w_addrok) begin
         r_araddr <= inst_sram_addr;
         r_arsize <= {1'b0, inst_sram_size};
      end
   end

   // Return path: one-cycle dataok/bus error pulse and held instruction word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_dataok  <= 1'b0;
         r_bus_err <= 1'b0;
         r_rdata   <= 32'h0000_0000;
      end else begin
         r_dataok  <= w_take;
         r_bus_err <= w_take && (rresp != AXI_RESP_OKAY);
         if (w_take) r_rdata <= rdata;
      end
   end

   assign inst_sram_addrok = w_addrok;
   assign inst_sram_dataok = r_dataok;
   assign inst_sram_rdata  = r_rdata;
   assign inst_bus_err     = r_bus_err;

   assign arid    = ARID_VAL;
   assign araddr  = r_araddr;
   assign arlen   = AXI_LEN_SINGLE;
   assign arsize  = r_arsize;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;
   assign arvalid = (r_state == AR_SEND);
   assign rready  = w_rready;

   inst_axi_bridge_chk #(
      .MAX_OUTST (MAX_OUTST)
   ) u_chk (
      .clk         (clk),
      .resetn      (resetn),
      .i_req       (inst_sram_req),
      .i_wr        (inst_sram_wr),
      .i_outst_cnt (r_outst_cnt),
      .i_drop_cnt  (r_drop_cnt)
   );

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Self-checking bench for inst_axi_bridge: directed cycle-level stimulus with
// a scoreboard queue of expected {bus_err, rdata} popped on every dataok.
module tb_inst_axi_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addrok;
   logic        inst_sram_dataok;
   logic [31:0] inst_sram_rdata;
   logic        data_wr_pending;
   logic        fetch_cancel;
   logic        inst_bus_err;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [32:0] sb_q[$];

   always #5 clk = ~clk;

   inst_axi_bridge #(
      .MAX_OUTST (2),
      .ARID_VAL  (4'd0)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .inst_sram_req    (inst_sram_req),
      .inst_sram_wr     (inst_sram_wr),
      .inst_sram_size   (inst_sram_size),
      .inst_sram_addr   (inst_sram_addr),
      .inst_sram_wdata  (inst_sram_wdata),
      .inst_sram_addrok (inst_sram_addrok),
      .inst_sram_dataok (inst_sram_dataok),
      .inst_sram_rdata  (inst_sram_rdata),
      .data_wr_pending  (data_wr_pending),
      .fetch_cancel     (fetch_cancel),
      .inst_bus_err     (inst_bus_err),
      .arid             (arid),
      .araddr           (araddr),
      .arlen            (arlen),
      .arsize           (arsize),
      .arburst          (arburst),
      .arlock           (arlock),
      .arcache          (arcache),
      .arprot           (arprot),
      .arvalid          (arvalid),
      .arready          (arready),
      .rid              (rid),
      .rdata            (rdata),
      .rresp            (rresp),
      .rlast            (rlast),
      .rvalid           (rvalid),
      .rready           (rready)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Every dataok must match the oldest expected response.
   always @(negedge clk) begin
      if (inst_sram_dataok) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_dataok", {31'd0, inst_sram_dataok}, 32'd0);
         end else begin
            logic [32:0] e;
            e = sb_q.pop_front();
            check_val("sb_rdata", inst_sram_rdata, e[31:0]);
            check_val("sb_bus_err", {31'd0, inst_bus_err}, {31'd0, e[32]});
         end
      end else begin
         check_val("bus_err_without_dataok", {31'd0, inst_bus_err}, 32'd0);
      end
   end

   // Accept at T, AR at T+1, R at T+2, dataok at T+3; caller sits just after an edge.
   task automatic single_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
      inst_sram_req  = 1'b1;
      inst_sram_addr = addr;
      inst_sram_size = 2'd2;
      arready        = 1'b1;
      settle();
      check_val({tag, "_addrok_T"}, {31'd0, inst_sram_addrok}, 32'd1);
      tick();
      inst_sram_req = 1'b0;
      settle();
      check_val({tag, "_arvalid_T1"}, {31'd0, arvalid}, 32'd1);
      check_val({tag, "_araddr_T1"}, araddr, addr);
      check_val({tag, "_arsize_T1"}, {29'd0, arsize}, 32'd2);
      check_val({tag, "_arlen"}, {24'd0, arlen}, 32'd0);
      check_val({tag, "_arburst"}, {30'd0, arburst}, 32'd1);
      check_val({tag, "_arid"}, {28'd0, arid}, 32'd0);
      tick();
      rvalid = 1'b1;
      rdata  = data;
      rresp  = 2'b00;
      rlast  = 1'b1;
      sb_q.push_back({1'b0, data});
      settle();
      check_val({tag, "_rready_T2"}, {31'd0, rready}, 32'd1);
      check_val({tag, "_dataok_T2"}, {31'd0, inst_sram_dataok}, 32'd0);
      tick();
      rvalid = 1'b0;
      settle();
      check_val({tag, "_dataok_T3"}, {31'd0, inst_sram_dataok}, 32'd1);
      check_val({tag, "_arvalid_T3"}, {31'd0, arvalid}, 32'd0);
      tick();
      settle();
      check_val({tag, "_dataok_T4"}, {31'd0, inst_sram_dataok}, 32'd0);
      check_val({tag, "_rdata_held"}, inst_sram_rdata, data);
      check_val({tag, "_rready_idle"}, {31'd0, rready}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn          = 1'b0;
      inst_sram_req   = 1'b1;
      inst_sram_wr    = 1'b0;
      inst_sram_size  = 2'd2;
      inst_sram_addr  = 32'hbfc0_0000;
      inst_sram_wdata = 32'h0000_0000;
      data_wr_pending = 1'b0;
      fetch_cancel    = 1'b0;
      arready         = 1'b0;
      rid             = 4'd0;
      rdata           = 32'h0000_0000;
      rresp           = 2'b00;
      rlast           = 1'b1;
      rvalid          = 1'b0;

      // Reset state, with a request already presented.
      #22;
      check_val("rst_addrok", {31'd0, inst_sram_addrok}, 32'd0);
      check_val("rst_arvalid", {31'd0, arvalid}, 32'd0);
      check_val("rst_dataok", {31'd0, inst_sram_dataok}, 32'd0);
      check_val("rst_bus_err", {31'd0, inst_bus_err}, 32'd0);
      check_val("rst_rdata", inst_sram_rdata, 32'd0);
      check_val("rst_rready", {31'd0, rready}, 32'd0);
      tick();
      resetn        = 1'b1;
      inst_sram_req = 1'b0;
      tick();

      // Single fetch.
      single_fetch("single", 32'hbfc0_0000, 32'h3c1d_0001);

      // Backpressure: AR stalled for 5 cycles, then outstanding limit.
      arready        = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0010;
      settle();
      check_val("bp_acc1", {31'd0, inst_sram_addrok}, 32'd1);
      tick();
      inst_sram_addr = 32'hbfc0_0014;
      settle();
      for (int i = 0; i < 5; i++) begin
         check_val("bp_arvalid_hold", {31'd0, arvalid}, 32'd1);
         check_val("bp_araddr_stable", araddr, 32'hbfc0_0010);
         check_val("bp_no_accept_in_send", {31'd0, inst_sram_addrok}, 32'd0);
         tick();
         settle();
      end
      arready = 1'b1;
      settle();
      check_val("bp_arvalid_at_hs", {31'd0, arvalid}, 32'd1);
      tick();
      settle();
      check_val("bp_acc2", {31'd0, inst_sram_addrok}, 32'd1);
      tick();
      inst_sram_addr = 32'hbfc0_0018;
      settle();
      check_val("bp_araddr2", araddr, 32'hbfc0_0014);
      check_val("bp_no_accept2", {31'd0, inst_sram_addrok}, 32'd0);
      tick();
      settle();
      check_val("bp_block_max1", {31'd0, inst_sram_addrok}, 32'd0);
      check_val("bp_arvalid_idle", {31'd0, arvalid}, 32'd0);
      tick();
      settle();
      check_val("bp_block_max2", {31'd0, inst_sram_addrok}, 32'd0);
      rvalid = 1'b1;
      rdata  = 32'h2408_0010;
      sb_q.push_back({1'b0, 32'h2408_0010});
      settle();
      check_val("bp_block_during_r", {31'd0, inst_sram_addrok}, 32'd0);
      tick();
      rdata = 32'h2408_0014;
      sb_q.push_back({1'b0, 32'h2408_0014});
      settle();
      check_val("bp_acc3_after_r", {31'd0, inst_sram_addrok}, 32'd1);
      tick();
      inst_sram_req = 1'b0;
      rvalid        = 1'b0;
      settle();
      check_val("bp_araddr3", araddr, 32'hbfc0_0018);
      check_val("bp_rready_one_left", {31'd0, rready}, 32'd1);
      tick();
      rvalid = 1'b1;
      rdata  = 32'h2408_0018;
      sb_q.push_back({1'b0, 32'h2408_0018});
      tick();
      rvalid = 1'b0;
      tick();
      tick();
      settle();
      check_val("bp_drained", {31'd0, rready}, 32'd0);

      // Cancel with two outstanding fetches, then a post-cancel fetch.
      arready        = 1'b1;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0004;
      settle();
      check_val("cx_acc4", {31'd0, inst_sram_addrok}, 32'd1);
      tick();
      inst_sram_req = 1'b0;
      tick();
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0008;
      settle();
      check_val("cx_acc8", {31'd0, inst_sram_addrok}, 32'd1);
      tick();
      inst_sram_req = 1'b0;
      tick();
      fetch_cancel = 1'b1;
      settle();
      check_val("cx_rready", {31'd0, rready}, 32'd1);
      tick();
      fetch_cancel = 1'b0;
      rvalid       = 1'b1;
      rdata        = 32'hdead_0004;
      settle();
      check_val("cx_dataok_0", {31'd0, inst_sram_dataok}, 32'd0);
      tick();
      rdata          = 32'hdead_0008;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0380;
      settle();
      check_val("cx_acc380", {31'd0, inst_sram_addrok}, 32'd1);
      check_val("cx_dataok_1", {31'd0, inst_sram_dataok}, 32'd0);
      tick();
      inst_sram_req = 1'b0;
      rvalid        = 1'b0;
      settle();
      check_val("cx_dataok_2", {31'd0, inst_sram_dataok}, 32'd0);
      check_val("cx_araddr380", araddr, 32'hbfc0_0380);
      tick();
      rvalid = 1'b1;
      rdata  = 32'h1122_3380;
      sb_q.push_back({1'b0, 32'h1122_3380});
      settle();
      check_val("cx_rdata_unchanged", inst_sram_rdata, 32'h2408_0018);
      tick();
      rvalid = 1'b0;
      settle();
      check_val("cx_dataok_380", {31'd0, inst_sram_dataok}, 32'd1);
      tick();

      // Data-side write hazard blocks acceptance.
      data_wr_pending = 1'b1;
      inst_sram_req   = 1'b1;
      inst_sram_addr  = 32'hbfc0_0400;
      for (int i = 0; i < 4; i++) begin
         settle();
         check_val("wh_blocked", {31'd0, inst_sram_addrok}, 32'd0);
         tick();
      end
      data_wr_pending = 1'b0;
      settle();
      check_val("wh_released", {31'd0, inst_sram_addrok}, 32'd1);
      tick();
      inst_sram_req = 1'b0;
      tick();
      rvalid = 1'b1;
      rdata  = 32'h8c88_0400;
      sb_q.push_back({1'b0, 32'h8c88_0400});
      tick();
      rvalid = 1'b0;
      tick();
      tick();

      // Error response.
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0500;
      settle();
      check_val("er_acc", {31'd0, inst_sram_addrok}, 32'd1);
      tick();
      inst_sram_req = 1'b0;
      tick();
      rvalid = 1'b1;
      rdata  = 32'hbadb_ad00;
      rresp  = 2'b10;
      sb_q.push_back({1'b1, 32'hbadb_ad00});
      tick();
      rvalid = 1'b0;
      rresp  = 2'b00;
      settle();
      check_val("er_dataok", {31'd0, inst_sram_dataok}, 32'd1);
      check_val("er_bus_err", {31'd0, inst_bus_err}, 32'd1);
      check_val("er_outst_dec", {31'd0, rready}, 32'd0);
      tick();
      settle();
      check_val("er_bus_err_pulse", {31'd0, inst_bus_err}, 32'd0);

      // Asynchronous reset while an AR is pending.
      arready        = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0600;
      settle();
      check_val("mr_acc", {31'd0, inst_sram_addrok}, 32'd1);
      tick();
      inst_sram_req = 1'b0;
      settle();
      check_val("mr_arvalid_before", {31'd0, arvalid}, 32'd1);
      #1;
      resetn = 1'b0;
      #1;
      check_val("mr_arvalid", {31'd0, arvalid}, 32'd0);
      check_val("mr_rready", {31'd0, rready}, 32'd0);
      check_val("mr_dataok", {31'd0, inst_sram_dataok}, 32'd0);
      check_val("mr_rdata", inst_sram_rdata, 32'd0);
      tick();
      resetn = 1'b1;
      tick();
      single_fetch("post_rst", 32'hbfc0_0700, 32'h2408_0700);

      tick();
      tick();
      check_val("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
